// File: rtl/pack_recv.sv
// Receive side of the framed byte stream: sync hunt on FF FF FF 7F, byte pairing into words, frame regrouping.
// Latency: WdAvail one clk after the completing byte; PacketCommit one clk after the last word of a frame.
// Backpressure: none; at most one byte per clk in, consumer must accept one word per two clk.
module pack_recv #(
    parameter int FRAME_WORDS  = 8,
    parameter int TIMEOUT_LOG2 = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  DataVal,
    input  logic        DataReady,
    output logic [15:0] PacketWd,
    output logic        WdAvail,
    output logic        PacketCommit,
    output logic        PacketReset,
    output logic        sync,
    output logic [7:0]  LostCount
);

    typedef enum logic [1:0] {HUNT, IDLE, FRAME, GOTFF} state_t;

    localparam logic [7:0] LAST_IDX = 8'(FRAME_WORDS - 1);
    localparam logic [TIMEOUT_LOG2-1:0] TMO_LAST = {{(TIMEOUT_LOG2-1){1'b1}}, 1'b0};

    state_t                  state, state_nx;
    logic [23:0]             shift, shift_nx;
    logic [7:0]              low_byte, low_byte_nx;
    logic                    odd, odd_nx;
    logic [7:0]              idx, idx_nx;
    logic [TIMEOUT_LOG2-1:0] idle_cnt, idle_cnt_nx;
    logic                    commit_pend, commit_pend_nx;
    logic [15:0]             wd_nx;
    logic                    wd_vld_nx, commit_nx, reset_nx, sync_nx;
    logic [7:0]              lost_nx;
    logic [15:0]             word;
    logic                    loss;

    assign word = {DataVal, low_byte};

    always_comb begin
        state_nx       = state;
        shift_nx       = shift;
        low_byte_nx    = low_byte;
        odd_nx         = odd;
        idx_nx         = idx;
        idle_cnt_nx    = idle_cnt;
        commit_pend_nx = 1'b0;
        wd_nx          = PacketWd;
        wd_vld_nx      = 1'b0;
        commit_nx      = commit_pend;
        reset_nx       = 1'b0;
        sync_nx        = sync;
        lost_nx        = LostCount;
        loss           = 1'b0;

        // Idle timer only runs while a frame or a word is partially received.
        if (DataReady) begin
            idle_cnt_nx = '0;
        end else if (state == FRAME || state == GOTFF || odd) begin
            if (idle_cnt == TMO_LAST) loss = 1'b1;
            else                      idle_cnt_nx = idle_cnt + 1'b1;
        end

        case (state)
            HUNT: begin
                if (DataReady) begin
                    shift_nx = {shift[15:0], DataVal};
                    if ({shift, DataVal} == 32'hFFFF_FF7F) begin
                        state_nx = IDLE;
                        sync_nx  = 1'b1;
                        odd_nx   = 1'b0;
                        idx_nx   = '0;
                    end
                end
            end
            IDLE: begin
                if (DataReady) begin
                    low_byte_nx = DataVal;
                    odd_nx      = 1'b1;
                    state_nx    = FRAME;
                end
            end
            FRAME: begin
                if (DataReady) begin
                    if (!odd) begin
                        low_byte_nx = DataVal;
                        odd_nx      = 1'b1;
                    end else begin
                        odd_nx = 1'b0;
                        if (idx == 8'd0 && word == 16'hFFFF) begin
                            state_nx = GOTFF;
                        end else if (idx == 8'd0 && word == 16'h7FFF) begin
                            state_nx = IDLE;
                        end else begin
                            wd_nx     = word;
                            wd_vld_nx = 1'b1;
                            if (idx == LAST_IDX) begin
                                idx_nx         = '0;
                                commit_pend_nx = 1'b1;
                                state_nx       = IDLE;
                            end else begin
                                idx_nx = idx + 8'd1;
                            end
                        end
                    end
                end
            end
            GOTFF: begin
                if (DataReady) begin
                    if (!odd) begin
                        low_byte_nx = DataVal;
                        odd_nx      = 1'b1;
                    end else begin
                        odd_nx = 1'b0;
                        if (word == 16'h7FFF) state_nx = IDLE;
                        else                  loss     = 1'b1;
                    end
                end
            end
            default: state_nx = HUNT;
        endcase

        // Loss wins over everything else; the shift reg is cleared so a full marker is needed again.
        if (loss) begin
            reset_nx    = (idx != 8'd0);
            lost_nx     = LostCount + {7'd0, (LostCount != 8'hFF)};
            sync_nx     = 1'b0;
            state_nx    = HUNT;
            shift_nx    = '0;
            odd_nx      = 1'b0;
            idx_nx      = '0;
            idle_cnt_nx = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= HUNT;
            shift        <= '0;
            low_byte     <= '0;
            odd          <= 1'b0;
            idx          <= '0;
            idle_cnt     <= '0;
            commit_pend  <= 1'b0;
            PacketWd     <= '0;
            WdAvail      <= 1'b0;
            PacketCommit <= 1'b0;
            PacketReset  <= 1'b0;
            sync         <= 1'b0;
            LostCount    <= '0;
        end else begin
            state        <= state_nx;
            shift        <= shift_nx;
            low_byte     <= low_byte_nx;
            odd          <= odd_nx;
            idx          <= idx_nx;
            idle_cnt     <= idle_cnt_nx;
            commit_pend  <= commit_pend_nx;
            PacketWd     <= wd_nx;
            WdAvail      <= wd_vld_nx;
            PacketCommit <= commit_nx;
            PacketReset  <= reset_nx;
            sync         <= sync_nx;
            LostCount    <= lost_nx;
        end
    end

endmodule
